// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall indices, widths, FSM encodings and redirect constants
package pipe_ctrl_pkg;

    localparam int STALL_W  = 6;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DEFER = 2'd1,
        ST_FLUSH = 2'd2
    } pipe_state_e;

    // A stall request from a stage freezes that stage and everything upstream of it.
    function automatic logic [STALL_W-1:0] stall_upto(input int upto);
        logic [STALL_W-1:0] v;
        for (int i = 0; i < STALL_W; i++) begin
            v[i] = (i <= upto);
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_stall_cnt.sv
// rtl/pipe_stall_cnt.sv - saturating PC-stall cycle counter
module pipe_stall_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect control; PIPE_STALL_CNT_EN enables the stall counter
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                exc_valid_i,
    input  logic                exc_eret_i,
    input  logic [31:0]         cp0_epc_i,
    output logic [STALL_W-1:0]  stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic [31:0]         stall_cnt_o
);

    pipe_state_e        state_q, state_d;
    logic [31:0]        target_q, target_d;
    logic [31:0]        new_pc_q, new_pc_d;
    logic               flush_q, flush_d;
    logic [STALL_W-1:0] stall_c;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        stall_c  = '0;
        case (state_q)
            ST_RUN: begin
                if (exc_valid_i) begin
                    target_d = exc_eret_i ? cp0_epc_i : EXC_VECTOR;
                    stall_c  = stall_upto(STALL_MEM);
                    state_d  = stallreq_mem ? ST_DEFER : ST_FLUSH;
                end else if (stallreq_mem) begin
                    stall_c = stall_upto(STALL_MEM);
                end else if (stallreq_ex) begin
                    stall_c = stall_upto(STALL_EX);
                end else if (stallreq_id) begin
                    stall_c = stall_upto(STALL_ID);
                end
            end
            ST_DEFER: begin
                // Hold the redirect until the outstanding bus access completes.
                stall_c = stall_upto(STALL_MEM);
                if (!stallreq_mem) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        flush_d  = (state_d == ST_FLUSH);
        new_pc_d = flush_d ? target_d : new_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            target_q <= 32'h0;
            new_pc_q <= 32'h0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            new_pc_q <= new_pc_d;
            flush_q  <= flush_d;
        end
    end

    assign stall  = stall_c;
    assign flush  = flush_q;
    assign new_pc = new_pc_q;

`ifdef PIPE_STALL_CNT_EN
    pipe_stall_cnt u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_c[STALL_PC]),
        .cnt_o (stall_cnt_o)
    );
`else
    assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic        exc_valid_i, exc_eret_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt_o;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .exc_valid_i  (exc_valid_i),
        .exc_eret_i   (exc_eret_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk = ~clk;

`ifdef PIPE_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] npc;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    typedef struct {
        logic       id, ex, mem;
        logic [5:0] stall;
    } vec_t;

    exp_t        sb[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] cnt_m  = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge: drive one cycle of inputs, check at the falling edge.
    task automatic cyc(input logic id, input logic ex, input logic mem,
                       input logic exv, input logic eret, input logic [31:0] epc,
                       input logic [5:0] es, input logic ef, input logic [31:0] enpc,
                       input string nm);
        exp_t e;
        stallreq_id  = id;
        stallreq_ex  = ex;
        stallreq_mem = mem;
        exc_valid_i  = exv;
        exc_eret_i   = eret;
        cp0_epc_i    = epc;
        e.stall = es;
        e.flush = ef;
        e.npc   = enpc;
        e.cnt   = CNT_EN ? cnt_m : 32'h0;
        e.name  = nm;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.name, ".stall"}, {26'h0, stall}, {26'h0, e.stall});
        chk({e.name, ".flush"}, {31'h0, flush}, {31'h0, e.flush});
        chk({e.name, ".new_pc"}, new_pc, e.npc);
        chk({e.name, ".cnt"}, stall_cnt_o, e.cnt);
        if (rst) cnt_m = 32'h0;
        else if (e.stall[0] && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [5:0] es, input logic ef, input logic [31:0] enpc, input string nm);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, es, ef, enpc, nm);
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b0, 6'b000000};
        vt[1] = '{1'b1, 1'b0, 1'b0, 6'b000111};
        vt[2] = '{1'b0, 1'b1, 1'b0, 6'b001111};
        vt[3] = '{1'b1, 1'b1, 1'b0, 6'b001111};
        vt[4] = '{1'b0, 1'b0, 1'b1, 6'b011111};
        vt[5] = '{1'b1, 1'b0, 1'b1, 6'b011111};
        vt[6] = '{1'b0, 1'b1, 1'b1, 6'b011111};
        vt[7] = '{1'b1, 1'b1, 1'b1, 6'b011111};

        rst = 1'b1;
        stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        exc_valid_i = 0; exc_eret_i = 0; cp0_epc_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cnt_m = 32'h0;

        for (int i = 0; i < 3; i++) idle(6'b000000, 1'b0, 32'h0, "reset");

        for (int i = 0; i < 8; i++)
            cyc(vt[i].id, vt[i].ex, vt[i].mem, 1'b0, 1'b0, 32'h0, vt[i].stall, 1'b0, 32'h0, "table");

        // Exception with the bus idle
        cyc(0, 0, 0, 1, 0, 32'h0, 6'b011111, 1'b0, 32'h0, "exc_n");
        idle(6'b000000, 1'b1, 32'h20, "exc_n1");
        idle(6'b000000, 1'b0, 32'h20, "exc_n2");

        // Exception with simultaneous stall requests wins
        cyc(1, 1, 0, 1, 0, 32'h0, 6'b011111, 1'b0, 32'h20, "exc_stall");
        idle(6'b000000, 1'b1, 32'h20, "exc_stall_fl");

        // eret with the bus busy for three cycles
        cyc(0, 0, 1, 1, 1, 32'h8000_1234, 6'b011111, 1'b0, 32'h20, "eret_n");
        cyc(0, 0, 1, 0, 0, 32'h5555_0000, 6'b011111, 1'b0, 32'h20, "eret_d1");
        cyc(0, 0, 1, 0, 0, 32'h5555_0000, 6'b011111, 1'b0, 32'h20, "eret_d2");
        cyc(0, 0, 0, 0, 0, 32'h0, 6'b011111, 1'b0, 32'h20, "eret_d3");
        idle(6'b000000, 1'b1, 32'h8000_1234, "eret_fl");
        idle(6'b000000, 1'b0, 32'h8000_1234, "eret_post");

        // Second exceptions during DEFER and FLUSH are ignored
        cyc(0, 0, 1, 1, 1, 32'h1111_0000, 6'b011111, 1'b0, 32'h8000_1234, "dbl_n");
        cyc(0, 0, 1, 1, 1, 32'hDEAD_0000, 6'b011111, 1'b0, 32'h8000_1234, "dbl_d1");
        cyc(0, 0, 0, 1, 0, 32'hBEEF_0000, 6'b011111, 1'b0, 32'h8000_1234, "dbl_d2");
        cyc(1, 1, 1, 1, 1, 32'hCAFE_0000, 6'b000000, 1'b1, 32'h1111_0000, "dbl_fl");
        idle(6'b000000, 1'b0, 32'h1111_0000, "dbl_post");
        idle(6'b000000, 1'b0, 32'h1111_0000, "dbl_post2");

        // Reset in DEFER aborts the redirect
        cyc(0, 0, 1, 1, 1, 32'h2222_0000, 6'b011111, 1'b0, 32'h1111_0000, "rst_n");
        cyc(0, 0, 1, 0, 0, 32'h0, 6'b011111, 1'b0, 32'h1111_0000, "rst_d1");
        rst = 1'b1;
        cyc(0, 0, 1, 0, 0, 32'h0, 6'b011111, 1'b0, 32'h1111_0000, "rst_in");
        rst = 1'b0;
        idle(6'b000000, 1'b0, 32'h0, "rst_post1");
        idle(6'b000000, 1'b0, 32'h0, "rst_post2");
        idle(6'b000000, 1'b0, 32'h0, "rst_post3");

        // Five stalled cycles then observe the count
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 32'h0, 6'b000111, 1'b0, 32'h0, "cnt5");
        idle(6'b000000, 1'b0, 32'h0, "cnt5_chk");
        if (CNT_EN) chk("cnt5_val", cnt_m, 32'd5);

`ifdef PIPE_STALL_CNT_EN
        dut.u_cnt.cnt_q = 32'hFFFF_FFFE;
        cnt_m = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 32'h0, 6'b001111, 1'b0, 32'h0, "sat");
        idle(6'b000000, 1'b0, 32'h0, "sat_chk");
        chk("sat_val", stall_cnt_o, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit and the producer side of the per-stage `stall`/`flush` interface consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It merges stall requests from ID (load-use), EX (multi-cycle divide) and MEM (bus wait) into a one-hot-prefix stall vector. It sequences exception and `eret` redirection: it freezes the pipeline, defers the redirect while the bus is busy, then issues a one-cycle flush together with the new PC.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect target for every exception other than `eret`.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- stallreq_id  in  1  ID-stage hazard stall request.
- stallreq_ex  in  1  EX-stage multi-cycle stall request.
- stallreq_mem  in  1  MEM-stage bus-wait stall request.
- exc_valid_i  in  1  MEM stage holds an excepting instruction or `eret`.
- exc_eret_i  in  1  qualifies `exc_valid_i`: 1 = `eret`.
- cp0_epc_i  in  32  EPC value from CP0, sampled when an `eret` is accepted.
- stall  out  6  per-stage freeze: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush  out  1  kills all pipeline registers for exactly one cycle.
- new_pc  out  32  redirect target, valid while `flush`=1.
- stall_cnt_o  out  32  cycle count of PC stalls (see Configuration).

## Operation
- States: RUN, DEFER, FLUSH. The state, `new_pc` and `flush` are registered.
- RUN, no exception: `stall` is combinational, with priority highest stage first.
  - `stallreq_mem` gives 6'b011111.
  - else `stallreq_ex` gives 6'b001111.
  - else `stallreq_id` gives 6'b000111.
  - else 6'b000000.
- RUN, `exc_valid_i`=1:
  - Latch the target: `cp0_epc_i` if `exc_eret_i`, else EXC_VECTOR.
  - Drive `stall`=6'b011111 this cycle.
  - Next state is DEFER if `stallreq_mem`=1, else FLUSH.
- DEFER:
  - `stall`=6'b011111 and the latched target is held.
  - New `exc_valid_i` events are ignored.
  - When `stallreq_mem`=0, next state is FLUSH.
- FLUSH:
  - `flush`=1, `new_pc` = latched target, `stall`=6'b000000.
  - All stall requests and `exc_valid_i` are ignored this cycle, because the requesting instructions are being killed.
  - Next state is RUN.
- Outside FLUSH, `flush`=0 and `new_pc` holds its last value.
- Simultaneous exception and any stall request in RUN: the exception wins and the stall vector is 6'b011111.

## Timing
- Reset: state RUN, `stall`=0, `flush`=0, `new_pc`=0, `stall_cnt_o`=0.
- Reset asserted mid-DEFER or mid-FLUSH aborts the redirect. The latched target is discarded, and no flush is issued after reset is released.
- Stall latency: 0 cycles (combinational from the requests in RUN).
- Exception with the bus idle: accepted in cycle N, `flush`=1 in cycle N+1, back in RUN at N+2.
- Exception with the bus busy: `flush` rises in the cycle after the first cycle in which `stallreq_mem`=0 while in DEFER.
- `flush` is never high for two consecutive cycles.
- `flush` and `stall` are never nonzero in the same cycle.

## Configuration
- Macro `PIPE_STALL_CNT_EN`.
- Defined:
  - `stall_cnt_o` increments every cycle in which `stall[0]`=1.
  - It saturates at 32'hFFFF_FFFF and does not wrap.
  - `rst` clears it.
- Undefined: the counter logic is removed and `stall_cnt_o` is tied to 32'h0. The port list is unchanged.

## Structure
- `defines.vh` (the shared header) gains the following, and the stage registers use the same bit-index names:
  - the stall bit indices (`STALL_PC` … `STALL_WB`),
  - the stall vector width,
  - the RUN/DEFER/FLUSH state encodings,
  - the default exception vector constant.
- One sub-module, `pipe_stall_cnt` (saturating counter), is instantiated only under `PIPE_STALL_CNT_EN`.

## Test plan
- Reset released with all inputs 0 -> `stall`=0, `flush`=0, `new_pc`=0 for 3 cycles.
- `stallreq_id` and `stallreq_ex` both 1 -> `stall`=6'b001111; then `stallreq_mem` also 1 -> 6'b011111.
- `exc_valid_i`=1, `exc_eret_i`=0, bus idle, cycle N -> `stall`=6'b011111 in N, then `flush`=1 and `new_pc`=32'h0000_0020 in N+1, then `flush`=0 in N+2.
- `eret` with `cp0_epc_i`=32'h8000_1234 while `stallreq_mem` is held for 3 cycles -> `stall`=6'b011111 throughout, then `flush`=1 and `new_pc`=32'h8000_1234 exactly one cycle after `stallreq_mem` falls.
- A second `exc_valid_i` during DEFER and during FLUSH -> ignored, `new_pc` keeps the first target, and a single flush pulse is issued. `rst` asserted in DEFER -> no flush after release.
- With `PIPE_STALL_CNT_EN`: 5 stalled cycles give `stall_cnt_o`=5. Counter forced to 32'hFFFF_FFFE plus 3 stalled cycles gives 32'hFFFF_FFFF. Without the macro, `stall_cnt_o`=0 always.
